// File: rtl/m23lc512_sram.sv
// rtl/m23lc512_sram.sv - 64 KiB SPI SRAM, 23LC512 single-I/O command set
// Inputs sample on rising SCK, SO updates on falling SCK; CS_N high aborts any frame.

module m23lc512_sram (
    input  logic SCK,
    input  logic RESET,
    input  logic CS_N,
    input  logic SI_SIO0,
    output tri   SO_SIO1,
    input  logic HOLD_N_SIO3
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA_RD, DATA_WR, MODE_RD, MODE_WR, IGNORE
    } state_t;

    logic [7:0]  mem [0:65535];
    state_t      state;
    logic [3:0]  cnt;
    logic [14:0] sr;
    logic [15:0] addr;
    logic [15:0] addr_next;
    logic [15:0] shift_in;
    logic        is_read;
    logic [7:0]  tx;
    logic [1:0]  mode;
    logic        armed;
    logic        so_en;
    logic        so_bit;
    logic        rst_txn;
    logic        byte_mode;
    logic        wr_commit;
    logic        mode_commit;

    assign rst_txn     = RESET | CS_N;
    assign shift_in    = {sr, SI_SIO0};
    assign byte_mode   = (mode == 2'b00) || (mode == 2'b11);
    assign wr_commit   = (state == DATA_WR) && (cnt == 4'd7) && HOLD_N_SIO3;
    assign mode_commit = (state == MODE_WR) && (cnt == 4'd7) && HOLD_N_SIO3;

    always_comb begin
        addr_next = addr + 16'd1;
        if (mode == 2'b10)
            addr_next = {addr[15:5], addr[4:0] + 5'd1};
    end

    // Only a CS_N falling edge seen outside reset may open a frame.
    always_ff @(negedge CS_N or posedge RESET) begin
        if (RESET)
            armed <= 1'b0;
        else
            armed <= 1'b1;
    end

    always_ff @(posedge SCK or posedge RESET) begin
        if (RESET)
            mode <= 2'b01;
        else if (mode_commit)
            mode <= shift_in[7:6];
    end

    always_ff @(posedge SCK) begin
        if (wr_commit)
            mem[addr] <= shift_in[7:0];
    end

    always_ff @(posedge SCK or posedge rst_txn) begin
        if (rst_txn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            sr      <= 15'd0;
            addr    <= 16'd0;
            is_read <= 1'b0;
            tx      <= 8'd0;
        end else if (HOLD_N_SIO3) begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        sr    <= shift_in[14:0];
                        cnt   <= 4'd1;
                        state <= CMD;
                    end
                end
                CMD: begin
                    sr  <= shift_in[14:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt <= 4'd0;
                        case (shift_in[7:0])
                            8'h03: begin state <= ADDR; is_read <= 1'b1; end
                            8'h02: begin state <= ADDR; is_read <= 1'b0; end
                            8'h05: begin state <= MODE_RD; tx <= {mode, 6'd0}; end
                            8'h01: state <= MODE_WR;
                            default: state <= IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    sr  <= shift_in[14:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        cnt  <= 4'd0;
                        addr <= shift_in;
                        if (is_read) begin
                            state <= DATA_RD;
                            tx    <= mem[shift_in];
                        end else begin
                            state <= DATA_WR;
                        end
                    end
                end
                DATA_RD: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt  <= 4'd0;
                        addr <= addr_next;
                        tx   <= mem[addr_next];
                        if (byte_mode)
                            state <= IGNORE;
                    end
                end
                DATA_WR: begin
                    sr  <= shift_in[14:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt  <= 4'd0;
                        addr <= addr_next;
                        if (byte_mode)
                            state <= IGNORE;
                    end
                end
                MODE_RD: begin
                    cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                end
                MODE_WR: begin
                    sr  <= shift_in[14:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7)
                        state <= IGNORE;
                end
                default: ;
            endcase
        end
    end

    // The bit for the upcoming rising edge is presented on the preceding falling edge.
    always_ff @(negedge SCK or posedge rst_txn) begin
        if (rst_txn) begin
            so_en  <= 1'b0;
            so_bit <= 1'b0;
        end else if (HOLD_N_SIO3) begin
            if (state == DATA_RD || state == MODE_RD) begin
                so_en  <= 1'b1;
                so_bit <= tx[3'd7 - cnt[2:0]];
            end else begin
                so_en  <= 1'b0;
            end
        end
    end

    assign SO_SIO1 = (so_en && HOLD_N_SIO3) ? so_bit : 1'bz;

endmodule

// File: tb/tb_m23lc512_sram.sv
// tb/tb_m23lc512_sram.sv - randomized bench for m23lc512_sram against an array model
// A released SO line reads as 1 through the pull-up.

module tb_m23lc512_sram;

    typedef logic [7:0] bq_t[$];

    logic SCK    = 1'b0;
    logic RESET  = 1'b1;
    logic CS_N   = 1'b1;
    logic SI     = 1'b0;
    logic HOLD_N = 1'b1;
    wire  so_line;

    pullup (so_line);

    m23lc512_sram dut (
        .SCK         (SCK),
        .RESET       (RESET),
        .CS_N        (CS_N),
        .SI_SIO0     (SI),
        .SO_SIO1     (so_line),
        .HOLD_N_SIO3 (HOLD_N)
    );

    always #5 SCK = ~SCK;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model_mem [int];
    logic [1:0] model_mode = 2'b01;

    function automatic logic [15:0] model_next(input logic [15:0] a);
        if (model_mode == 2'b10)
            return (a & 16'hFFE0) | ((a + 16'd1) & 16'h001F);
        return a + 16'd1;
    endfunction

    function automatic bit model_single();
        return (model_mode == 2'b00) || (model_mode == 2'b11);
    endfunction

    task automatic model_write(input logic [15:0] a, input bq_t d);
        logic [15:0] p;
        p = a;
        foreach (d[i]) begin
            model_mem[int'(p)] = d[i];
            if (model_single()) break;
            p = model_next(p);
        end
    endtask

    task automatic clk_cycle();
        @(posedge SCK);
        @(negedge SCK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SI = b;
        clk_cycle();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            #2;
            v[i] = so_line;
            SI = 1'($urandom_range(0, 1));
            clk_cycle();
        end
    endtask

    task automatic cs_begin();
        @(negedge SCK);
        #1;
        CS_N = 1'b0;
    endtask

    task automatic cs_end();
        CS_N = 1'b1;
        SI   = 1'b0;
        clk_cycle();
    endtask

    task automatic spi_write(input logic [15:0] a, input bq_t d);
        cs_begin();
        send_byte(8'h02);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        foreach (d[i]) send_byte(d[i]);
        cs_end();
    endtask

    task automatic spi_read(input logic [15:0] a, input int n, output bq_t q);
        logic [7:0] b;
        q.delete();
        cs_begin();
        send_byte(8'h03);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            q.push_back(b);
        end
        cs_end();
    endtask

    task automatic spi_wrmr(input logic [7:0] v);
        cs_begin();
        send_byte(8'h01);
        send_byte(v);
        cs_end();
        model_mode = v[7:6];
    endtask

    task automatic spi_rdmr(input int n, output bq_t q);
        logic [7:0] b;
        q.delete();
        cs_begin();
        send_byte(8'h05);
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            q.push_back(b);
        end
        cs_end();
    endtask

    task automatic test_reset();
        bq_t q;
        repeat (3) @(negedge SCK);
        #1;
        n_vec++;
        if (so_line !== 1'b1) begin
            n_err++;
            $display("FAIL reset_so: got %b expected released (1)", so_line);
        end
        RESET = 1'b0;
        model_mode = 2'b01;
        spi_rdmr(2, q);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q[i] !== 8'h40) begin
                n_err++;
                $display("FAIL reset_mode[%0d]: got %02h expected 40", i, q[i]);
            end
        end
    endtask

    task automatic test_basic_rw();
        bq_t d, q;
        d.push_back(8'hA5);
        spi_write(16'h1234, d);
        model_write(16'h1234, d);
        spi_read(16'h1234, 1, q);
        n_vec++;
        if (q[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_read: got %02h expected a5", q[0]);
        end
    endtask

    task automatic test_sequential();
        bq_t d, q;
        d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
        spi_write(16'hFFFE, d);
        model_write(16'hFFFE, d);
        spi_read(16'hFFFE, 3, q);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (q[i] !== d[i]) begin
                n_err++;
                $display("FAIL seq_read[%0d]: got %02h expected %02h", i, q[i], d[i]);
            end
        end
        spi_read(16'h0000, 1, q);
        n_vec++;
        if (q[0] !== 8'h33) begin
            n_err++;
            $display("FAIL seq_wrap: got %02h expected 33", q[0]);
        end
    endtask

    task automatic test_page();
        bq_t d, q;
        d.push_back(8'h5C);
        spi_write(16'h0020, d);
        model_write(16'h0020, d);
        spi_wrmr(8'h80);
        spi_rdmr(1, q);
        n_vec++;
        if (q[0] !== 8'h80) begin
            n_err++;
            $display("FAIL page_rdmr: got %02h expected 80", q[0]);
        end
        d.delete();
        d.push_back(8'hAA); d.push_back(8'hBB);
        spi_write(16'h001F, d);
        model_write(16'h001F, d);
        spi_read(16'h0000, 1, q);
        n_vec++;
        if (q[0] !== 8'hBB) begin
            n_err++;
            $display("FAIL page_wrap: got %02h expected bb", q[0]);
        end
        spi_read(16'h0020, 1, q);
        n_vec++;
        if (q[0] !== 8'h5C) begin
            n_err++;
            $display("FAIL page_next_untouched: got %02h expected 5c", q[0]);
        end
        spi_read(16'h001F, 2, q);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q[i] !== d[i]) begin
                n_err++;
                $display("FAIL page_read[%0d]: got %02h expected %02h", i, q[i], d[i]);
            end
        end
    endtask

    task automatic test_byte_mode();
        bq_t d, q;
        spi_wrmr(8'h40);
        d.push_back(8'h77); d.push_back(8'h66);
        spi_write(16'h0100, d);
        model_write(16'h0100, d);
        spi_wrmr(8'h00);
        d.delete();
        d.push_back(8'h12); d.push_back(8'h34);
        spi_write(16'h0100, d);
        model_write(16'h0100, d);
        spi_read(16'h0100, 2, q);
        n_vec++;
        if (q[0] !== 8'h12) begin
            n_err++;
            $display("FAIL byte_first: got %02h expected 12", q[0]);
        end
        n_vec++;
        if (q[1] !== 8'hFF) begin
            n_err++;
            $display("FAIL byte_so_release: got %02h expected ff (released)", q[1]);
        end
        spi_read(16'h0101, 1, q);
        n_vec++;
        if (q[0] !== 8'h66) begin
            n_err++;
            $display("FAIL byte_second_unchanged: got %02h expected 66", q[0]);
        end
        spi_wrmr(8'hFF);
        spi_rdmr(1, q);
        n_vec++;
        if (q[0] !== 8'hC0) begin
            n_err++;
            $display("FAIL mode_low_bits: got %02h expected c0", q[0]);
        end
        spi_wrmr(8'h40);
    endtask

    task automatic test_abort();
        bq_t d, q;
        logic [7:0] p;
        d.push_back(8'h3C); d.push_back(8'h00);
        spi_write(16'h2000, d);
        model_write(16'h2000, d);
        cs_begin();
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
        p = 8'hC3;
        for (int i = 7; i > 2; i--) send_bit(p[i]);
        cs_end();
        cs_begin();
        send_byte(8'h03); send_byte(8'h20); send_byte(8'h01);
        #2;
        n_vec++;
        if (so_line !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pre_driven: got %b expected 0", so_line);
        end
        repeat (3) clk_cycle();
        CS_N = 1'b1;
        #1;
        n_vec++;
        if (so_line !== 1'b1) begin
            n_err++;
            $display("FAIL abort_so_release: got %b expected released (1)", so_line);
        end
        clk_cycle();
        spi_read(16'h2000, 1, q);
        n_vec++;
        if (q[0] !== 8'h3C) begin
            n_err++;
            $display("FAIL abort_partial_write: got %02h expected 3c", q[0]);
        end
    endtask

    task automatic test_hold();
        bq_t d, q;
        logic [7:0] b;
        d.push_back(8'h9A); d.push_back(8'h5B);
        cs_begin();
        send_byte(8'h02); send_byte(8'h30); send_byte(8'h00);
        for (int i = 7; i > 3; i--) send_bit(d[0][i]);
        HOLD_N = 1'b0;
        repeat (6) send_bit(1'($urandom_range(0, 1)));
        HOLD_N = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(d[0][i]);
        send_byte(d[1]);
        cs_end();
        model_write(16'h3000, d);
        spi_read(16'h3000, 2, q);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q[i] !== d[i]) begin
                n_err++;
                $display("FAIL hold_write[%0d]: got %02h expected %02h", i, q[i], d[i]);
            end
        end
        d.delete();
        d.push_back(8'h4D);
        spi_write(16'h3010, d);
        model_write(16'h3010, d);
        cs_begin();
        send_byte(8'h03); send_byte(8'h30); send_byte(8'h10);
        HOLD_N = 1'b0;
        #1;
        n_vec++;
        if (so_line !== 1'b1) begin
            n_err++;
            $display("FAIL hold_so_release: got %b expected released (1)", so_line);
        end
        repeat (4) clk_cycle();
        HOLD_N = 1'b1;
        recv_byte(b);
        cs_end();
        n_vec++;
        if (b !== 8'h4D) begin
            n_err++;
            $display("FAIL hold_read_frozen: got %02h expected 4d", b);
        end
    endtask

    task automatic test_reset_mid_read();
        bq_t d, q;
        d.push_back(8'h21);
        spi_write(16'h4000, d);
        model_write(16'h4000, d);
        spi_wrmr(8'h80);
        cs_begin();
        send_byte(8'h03); send_byte(8'h40); send_byte(8'h00);
        #2;
        n_vec++;
        if (so_line !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pre_driven: got %b expected 0", so_line);
        end
        clk_cycle();
        clk_cycle();
        RESET = 1'b1;
        #1;
        n_vec++;
        if (so_line !== 1'b1) begin
            n_err++;
            $display("FAIL rst_so_release: got %b expected released (1)", so_line);
        end
        clk_cycle();
        RESET = 1'b0;
        model_mode = 2'b01;
        send_byte(8'h05);
        for (int i = 0; i < 8; i++) begin
            #2;
            n_vec++;
            if (so_line !== 1'b1) begin
                n_err++;
                $display("FAIL rst_needs_new_cs[%0d]: got %b expected released (1)", i, so_line);
            end
            clk_cycle();
        end
        cs_end();
        spi_rdmr(1, q);
        n_vec++;
        if (q[0] !== 8'h40) begin
            n_err++;
            $display("FAIL rst_mode: got %02h expected 40", q[0]);
        end
        spi_read(16'h4000, 1, q);
        n_vec++;
        if (q[0] !== 8'h21) begin
            n_err++;
            $display("FAIL rst_mem_kept: got %02h expected 21", q[0]);
        end
    endtask

    task automatic test_random();
        bq_t d, q;
        logic [7:0]  mv;
        logic [7:0]  exp;
        logic [15:0] a, p;
        int n;
        bit have;
        for (int it = 0; it < 40; it++) begin
            mv = 8'($urandom);
            spi_wrmr(mv);
            spi_rdmr(1, q);
            n_vec++;
            if (q[0] !== {mv[7:6], 6'd0}) begin
                n_err++;
                $display("FAIL rand_rdmr[%0d]: got %02h expected %02h", it, q[0], {mv[7:6], 6'd0});
            end
            a = 16'($urandom);
            if (it % 3 == 0) a = a | 16'hFFFC;
            if (it % 3 == 1) a = a | 16'h001D;
            n = $urandom_range(1, 5);
            d.delete();
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            spi_write(a, d);
            model_write(a, d);
            spi_read(a, n + 1, q);
            p = a;
            for (int k = 0; k <= n; k++) begin
                have = 1'b0;
                exp  = 8'h00;
                if (k > 0 && model_single()) begin
                    have = 1'b1;
                    exp  = 8'hFF;
                end else if (model_mem.exists(int'(p))) begin
                    have = 1'b1;
                    exp  = model_mem[int'(p)];
                end
                if (have) begin
                    n_vec++;
                    if (q[k] !== exp) begin
                        n_err++;
                        $display("FAIL rand_read[%0d.%0d] mode=%b addr=%04h: got %02h expected %02h",
                                 it, k, model_mode, p, q[k], exp);
                    end
                end
                p = model_next(p);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_rw();
        test_sequential();
        test_page();
        test_byte_mode();
        test_abort();
        test_hold();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
